isqrt16_seq: RTL and testbench



---
 rtl/isqrt16_seq_if.sv | 29 ++
 rtl/isqrt16_seq.sv | 111 +++++++++++
 tb/tb_isqrt16_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/isqrt16_seq_if.sv
// Handshake bundle for the sequential integer square root unit.
// The upstream side presents a radicand with in_valid/in_ready; the
// downstream side takes root and remainder with out_valid/out_ready.
interface isqrt16_seq_if #(
  parameter int IN_W = 16
) ();
  localparam int OUT_W = IN_W / 2;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sq;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_root;
  logic [OUT_W:0]   out_rem;
  logic             busy;

  // Producer of radicands / consumer of results
  modport master (
    output in_valid, in_sq, out_ready,
    input  in_ready, out_valid, out_root, out_rem, busy
  );

  // The square root unit itself
  modport slave (
    input  in_valid, in_sq, out_ready,
    output in_ready, out_valid, out_root, out_rem, busy
  );
endinterface

// File: rtl/isqrt16_seq.sv
// Sequential digit-by-digit integer square root.
// Retires one root bit per clock: OUT_W iterations per radicand, then the
// result is held in DONE until the downstream handshake. The remainder is
// always the floor remainder; ROUND=1 only affects the reported root.
module isqrt16_seq #(
  parameter int IN_W  = 16,
  parameter int ROUND = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  isqrt16_seq_if.slave bus
);
  localparam int OUT_W = IN_W / 2;
  localparam int REM_W = OUT_W + 2;
  localparam int CNT_W = (OUT_W > 2) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    rad_q;
  logic [REM_W-1:0]   rem_q;
  logic [OUT_W-1:0]   root_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OUT_W-1:0]   out_root_q;
  logic [OUT_W:0]     out_rem_q;

  logic [REM_W-1:0]   rem_sh;
  logic [REM_W-1:0]   trial;
  logic               take;
  logic [REM_W-1:0]   rem_nx;
  logic [OUT_W-1:0]   root_nx;

  // Round-to-nearest on the floor root: bump when the remainder exceeds the
  // root (i.e. radicand >= root^2 + root + 1), saturating at all ones.
  function automatic logic [OUT_W-1:0] round_root(input logic [OUT_W-1:0] root,
                                                  input logic [REM_W-1:0] rem);
    if ((ROUND != 0) && (rem > {2'b00, root})) begin
      if (&root) return root;
      return root + OUT_W'(1);
    end
    return root;
  endfunction

  // One restoring iteration: bring down two radicand bits and try root*4+1
  always_comb begin
    rem_sh  = (rem_q << 2) | {{OUT_W{1'b0}}, rad_q[IN_W-1 -: 2]};
    trial   = {root_q, 2'b01};
    take    = (rem_sh >= trial);
    rem_nx  = take ? (rem_sh - trial) : rem_sh;
    root_nx = (root_q << 1) | {{(OUT_W-1){1'b0}}, take};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, iterate in CALC, hold until taken in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CALC;
      CALC:    if (cnt_q == '0)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Iteration registers and result capture on the last iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      out_root_q <= '0;
      out_rem_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            rad_q  <= bus.in_sq;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= CNT_W'(OUT_W - 1);
          end
        end
        CALC: begin
          rad_q  <= rad_q << 2;
          rem_q  <= rem_nx;
          root_q <= root_nx;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            out_root_q <= round_root(root_nx, rem_nx);
            out_rem_q  <= rem_nx[OUT_W:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_root  = out_root_q;
  assign bus.out_rem   = out_rem_q;

endmodule

// File: tb/tb_isqrt16_seq.sv
// Bench for isqrt16_seq: a floor instance and a rounding instance share the
// same stimulus so every transaction is checked against both variants.
module tb_isqrt16_seq;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b1;
  logic            in_valid  = 1'b0;
  logic [IN_W-1:0] in_sq     = '0;
  logic            out_ready = 1'b1;
  int              cyc       = 0;
  int              n_cmp     = 0;
  int              n_fail    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  isqrt16_seq_if #(.IN_W(IN_W)) bf ();
  isqrt16_seq_if #(.IN_W(IN_W)) br ();

  assign bf.in_valid  = in_valid;
  assign bf.in_sq     = in_sq;
  assign bf.out_ready = out_ready;
  assign br.in_valid  = in_valid;
  assign br.in_sq     = in_sq;
  assign br.out_ready = out_ready;

  isqrt16_seq #(.IN_W(IN_W), .ROUND(0)) dut_floor (.clk(clk), .rst_n(rst_n), .bus(bf.slave));
  isqrt16_seq #(.IN_W(IN_W), .ROUND(1)) dut_round (.clk(clk), .rst_n(rst_n), .bus(br.slave));

  // Offer one radicand and wait (bounded) for the result; leaves the bench
  // at #1 after the edge where out_valid first reads high. lat is counted in
  // edges after the accept edge; 20 means it never arrived.
  task automatic run_one(input logic [IN_W-1:0] v, output int lat, output int acc_cyc);
    int n;
    n = 0;
    while (bf.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    in_sq = v; in_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    in_valid = 1'b0; in_sq = ~v;
    lat = 0;
    while (bf.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (bf.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bf.in_ready); end
    n_cmp++; if (bf.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bf.out_valid); end
    n_cmp++; if (bf.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bf.busy); end
    n_cmp++; if (bf.out_root !== 8'd0) begin n_fail++; $display("FAIL rst_root: got %0d want 0", bf.out_root); end
    n_cmp++; if (bf.out_rem !== 9'd0) begin n_fail++; $display("FAIL rst_rem: got %0d want 0", bf.out_rem); end
    n_cmp++; if (br.out_valid !== 1'b0 || br.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_round_hs: got v=%b r=%b want v=0 r=1", br.out_valid, br.in_ready); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pythagorean();
    int lat, acc;
    out_ready = 1'b1;
    run_one(16'd25, lat, acc);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL t1_latency: got %0d want 8", lat); end
    n_cmp++; if (bf.out_root !== 8'd5) begin n_fail++; $display("FAIL t1_root: got %0d want 5", bf.out_root); end
    n_cmp++; if (bf.out_rem !== 9'd0) begin n_fail++; $display("FAIL t1_rem: got %0d want 0", bf.out_rem); end
    n_cmp++; if (br.out_root !== 8'd5) begin n_fail++; $display("FAIL t1_round_root: got %0d want 5", br.out_root); end
    n_cmp++; if (bf.busy !== 1'b1 || bf.in_ready !== 1'b0) begin n_fail++; $display("FAIL t1_done_flags: got busy=%b rdy=%b want 1 0", bf.busy, bf.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bf.out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_drop: got %b want 0", bf.out_valid); end
    n_cmp++; if (bf.in_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready_back: got %b want 1", bf.in_ready); end
    n_cmp++; if (bf.out_root !== 8'd5) begin n_fail++; $display("FAIL t1_root_hold: got %0d want 5", bf.out_root); end
  endtask

  task automatic test_extremes();
    int v[3]  = '{0, 65535, 65025};
    int fr[3] = '{0, 255, 255};
    int fm[3] = '{0, 510, 0};
    int rr[3] = '{0, 255, 255};
    int lat, acc;
    for (int i = 0; i < 3; i++) begin
      run_one(16'(v[i]), lat, acc);
      n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL ext_latency[%0d]: got %0d want 8", v[i], lat); end
      n_cmp++; if (bf.out_root !== 8'(fr[i])) begin n_fail++; $display("FAIL ext_root[%0d]: got %0d want %0d", v[i], bf.out_root, fr[i]); end
      n_cmp++; if (bf.out_rem !== 9'(fm[i])) begin n_fail++; $display("FAIL ext_rem[%0d]: got %0d want %0d", v[i], bf.out_rem, fm[i]); end
      n_cmp++; if (br.out_root !== 8'(rr[i])) begin n_fail++; $display("FAIL ext_round_root[%0d]: got %0d want %0d", v[i], br.out_root, rr[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rounding();
    int v[4]  = '{210, 211, 65535, 3};
    int fr[4] = '{14, 14, 255, 1};
    int fm[4] = '{14, 15, 510, 2};
    int rr[4] = '{14, 15, 255, 2};
    int lat, acc;
    for (int i = 0; i < 4; i++) begin
      run_one(16'(v[i]), lat, acc);
      n_cmp++; if (br.out_root !== 8'(rr[i])) begin n_fail++; $display("FAIL rnd_root[%0d]: got %0d want %0d", v[i], br.out_root, rr[i]); end
      n_cmp++; if (br.out_rem !== 9'(fm[i])) begin n_fail++; $display("FAIL rnd_rem[%0d]: got %0d want %0d", v[i], br.out_rem, fm[i]); end
      n_cmp++; if (bf.out_root !== 8'(fr[i])) begin n_fail++; $display("FAIL rnd_floor_root[%0d]: got %0d want %0d", v[i], bf.out_root, fr[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat, acc;
    out_ready = 1'b0;
    run_one(16'd100, lat, acc);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d want 8", lat); end
    in_sq = 16'd49; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bf.out_valid !== 1'b1 || bf.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_flags[%0d]: got v=%b r=%b want 1 0", i, bf.out_valid, bf.in_ready); end
      n_cmp++; if (bf.out_root !== 8'd10 || bf.out_rem !== 9'd0) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %0d/%0d want 10/0", i, bf.out_root, bf.out_rem); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bf.out_valid !== 1'b0 || bf.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b r=%b want 0 1", bf.out_valid, bf.in_ready); end
    run_one(16'd49, lat, acc);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL bp_next_latency: got %0d want 8", lat); end
    n_cmp++; if (bf.out_root !== 8'd7 || bf.out_rem !== 9'd0) begin n_fail++; $display("FAIL bp_next_result: got %0d/%0d want 7/0", bf.out_root, bf.out_rem); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    int lat, acc;
    in_sq = 16'd40000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bf.out_valid !== 1'b0 || bf.busy !== 1'b0 || bf.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_flags: got v=%b b=%b r=%b want 0 0 1", bf.out_valid, bf.busy, bf.in_ready); end
    n_cmp++; if (bf.out_root !== 8'd0 || bf.out_rem !== 9'd0) begin n_fail++; $display("FAIL rmid_data: got %0d/%0d want 0/0", bf.out_root, bf.out_rem); end
    @(negedge clk) rst_n = 1'b1;
    run_one(16'd40000, lat, acc);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL rmid_latency: got %0d want 8", lat); end
    n_cmp++; if (bf.out_root !== 8'd200 || bf.out_rem !== 9'd0) begin n_fail++; $display("FAIL rmid_result: got %0d/%0d want 200/0", bf.out_root, bf.out_rem); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, acc0, acc1;
    out_ready = 1'b1;
    run_one(16'd144, lat, acc0);
    n_cmp++; if (bf.out_root !== 8'd12) begin n_fail++; $display("FAIL b2b_root0: got %0d want 12", bf.out_root); end
    @(posedge clk); #1;
    run_one(16'd170, lat, acc1);
    n_cmp++; if (acc1 - acc0 !== 10) begin n_fail++; $display("FAIL b2b_period: got %0d want 10", acc1 - acc0); end
    n_cmp++; if (bf.out_root !== 8'd13 || bf.out_rem !== 9'd1) begin n_fail++; $display("FAIL b2b_result1: got %0d/%0d want 13/1", bf.out_root, bf.out_rem); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat, acc, r, rem, rnd, g, k;
    logic [IN_W-1:0] v;
    out_ready = 1'b0;
    for (int i = 0; i < 512; i++) begin
      v = 16'((i * 32771) & 32'hFFFF);
      r = 0;
      while ((r + 1) * (r + 1) <= int'(v)) r++;
      rem = int'(v) - r * r;
      rnd = (rem > r) ? ((r == 255) ? 255 : r + 1) : r;
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
      run_one(v, lat, acc);
      n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL sw_latency[%0d]: got %0d want 8", v, lat); end
      n_cmp++; if (bf.out_root !== 8'(r) || bf.out_rem !== 9'(rem)) begin n_fail++; $display("FAIL sw_floor[%0d]: got %0d/%0d want %0d/%0d", v, bf.out_root, bf.out_rem, r, rem); end
      n_cmp++; if (br.out_root !== 8'(rnd) || br.out_rem !== 9'(rem)) begin n_fail++; $display("FAIL sw_round[%0d]: got %0d/%0d want %0d/%0d", v, br.out_root, br.out_rem, rnd, rem); end
      k = $urandom_range(0, 2);
      repeat (k) begin
        @(posedge clk); #1;
        n_cmp++; if (bf.out_valid !== 1'b1 || bf.out_root !== 8'(r)) begin n_fail++; $display("FAIL sw_hold[%0d]: got v=%b root=%0d want 1/%0d", v, bf.out_valid, bf.out_root, r); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++; if (bf.out_valid !== 1'b0 || br.out_valid !== 1'b0) begin n_fail++; $display("FAIL sw_consumed[%0d]: got %b/%b want 0/0", v, bf.out_valid, br.out_valid); end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pythagorean();
    test_extremes();
    test_rounding();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
